// File: rtl/fractal_pkg.sv
// fractal_pkg: constants shared with tile_solver and the tile_dispatcher FSM encoding.
package fractal_pkg;
  localparam int DEFAULT_LIMB_INDEX_BITS = 6;
  localparam int DEFAULT_LIMB_SIZE_BITS = 27;
  typedef enum logic [2:0] {
    IDLE,
    WR_REAL,
    WR_IMAG,
    START,
    WAIT_DROP,
    WAIT_DONE
  } disp_state_e;
endpackage

// File: rtl/tile_job_buffer.sv
// tile_job_buffer: one-entry pending job register with valid/ready handshake.
module tile_job_buffer #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);
  // accept only when empty and pop only when full, so the two never collide
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ready_o <= 1'b1;
      full_o  <= 1'b0;
      data_o  <= '0;
    end else if (valid_i && ready_o) begin
      ready_o <= 1'b0;
      full_o  <= 1'b1;
      data_o  <= data_i;
    end else if (pop_i) begin
      ready_o <= 1'b1;
      full_o  <= 1'b0;
    end
endmodule

// File: rtl/tile_dispatcher.sv
// tile_dispatcher: buffers tile jobs and streams their limbs into tile_solver, then pulses start.
// Define TILE_DISPATCHER_STATS_EN to add the jobs_done and stall_cycles counters.
module tile_dispatcher
  import fractal_pkg::*;
#(
  parameter int LIMB_INDEX_BITS = DEFAULT_LIMB_INDEX_BITS,
  parameter int LIMB_SIZE_BITS  = DEFAULT_LIMB_SIZE_BITS,
  parameter int NUM_LIMBS       = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                job_valid,
  output logic                                job_ready,
  input  logic [NUM_LIMBS*LIMB_SIZE_BITS-1:0] job_real,
  input  logic [NUM_LIMBS*LIMB_SIZE_BITS-1:0] job_imag,
  input  logic [31:0]                         job_zoom,
  input  logic [31:0]                         job_addr,
  input  logic                                solver_ready,
  output logic                                write_real_en,
  output logic                                write_imag_en,
  output logic [LIMB_INDEX_BITS-1:0]          write_limb,
  output logic [LIMB_SIZE_BITS-1:0]           write_data,
  output logic [31:0]                         zoom_level,
  output logic [31:0]                         output_addr,
  output logic                                start,
  output logic                                busy
`ifdef TILE_DISPATCHER_STATS_EN
  ,
  output logic [31:0]                         jobs_done,
  output logic [31:0]                         stall_cycles
`endif
);
  localparam int CW = NUM_LIMBS * LIMB_SIZE_BITS;
  localparam int JW = 2 * CW + 64;
  localparam logic [LIMB_INDEX_BITS-1:0] LAST = LIMB_INDEX_BITS'(NUM_LIMBS - 1);

  disp_state_e                state_q, state_d;
  logic [LIMB_INDEX_BITS-1:0] cnt_q, cnt_d, limb_d;
  logic [CW-1:0]              real_q, real_d, imag_q, imag_d;
  logic [31:0]                zoom_d, addr_d;
  logic [LIMB_SIZE_BITS-1:0]  data_d;
  logic [JW-1:0]              pend_data;
  logic                       pend_full, pop, last, wr_real_d, wr_imag_d;

  assign last = cnt_q == LAST;

  tile_job_buffer #(.W(JW)) u_pending (
    .clock  (clock),
    .reset  (reset),
    .valid_i(job_valid),
    .ready_o(job_ready),
    .data_i ({job_real, job_imag, job_zoom, job_addr}),
    .pop_i  (pop),
    .full_o (pend_full),
    .data_o (pend_data)
  );

  // next state plus next values of every registered output, derived from the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    real_d  = real_q;
    imag_d  = imag_q;
    zoom_d  = zoom_level;
    addr_d  = output_addr;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (pend_full && solver_ready) begin
        pop = 1'b1;
        {real_d, imag_d, zoom_d, addr_d} = pend_data;
        cnt_d   = '0;
        state_d = WR_REAL;
      end
      WR_REAL: begin
        cnt_d   = last ? '0 : cnt_q + LIMB_INDEX_BITS'(1);
        state_d = last ? WR_IMAG : WR_REAL;
      end
      WR_IMAG: begin
        cnt_d   = last ? '0 : cnt_q + LIMB_INDEX_BITS'(1);
        state_d = last ? START : WR_IMAG;
      end
      START:     state_d = WAIT_DROP;
      WAIT_DROP: state_d = solver_ready ? WAIT_DROP : WAIT_DONE;
      WAIT_DONE: state_d = solver_ready ? IDLE : WAIT_DONE;
      default:   state_d = IDLE;
    endcase
    wr_real_d = state_d == WR_REAL;
    wr_imag_d = state_d == WR_IMAG;
    limb_d    = (wr_real_d || wr_imag_d) ? cnt_d : write_limb;
    data_d    = wr_real_d ? LIMB_SIZE_BITS'(real_d >> (32'(cnt_d) * LIMB_SIZE_BITS)) :
                wr_imag_d ? LIMB_SIZE_BITS'(imag_d >> (32'(cnt_d) * LIMB_SIZE_BITS)) : write_data;
  end

  // FSM, active job and registered solver-facing outputs
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      real_q        <= '0;
      imag_q        <= '0;
      zoom_level    <= '0;
      output_addr   <= '0;
      write_real_en <= 1'b0;
      write_imag_en <= 1'b0;
      write_limb    <= '0;
      write_data    <= '0;
      start         <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      real_q        <= real_d;
      imag_q        <= imag_d;
      zoom_level    <= zoom_d;
      output_addr   <= addr_d;
      write_real_en <= wr_real_d;
      write_imag_en <= wr_imag_d;
      write_limb    <= limb_d;
      write_data    <= data_d;
      start         <= state_d == START;
      busy          <= state_d != IDLE;
    end

`ifdef TILE_DISPATCHER_STATS_EN
  // completed-job counter wraps; stall counter saturates
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      jobs_done    <= '0;
      stall_cycles <= '0;
    end else begin
      if (state_q == WAIT_DONE && state_d == IDLE) jobs_done <= jobs_done + 32'd1;
      if (state_q == IDLE && pend_full && !solver_ready && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_tile_dispatcher.sv
// tb_tile_dispatcher: directed and randomized checks of tile_dispatcher against a timeline model.
module tb_tile_dispatcher;
  localparam int LIB = 2, LS = 27, N = 4, CW = N * LS;

  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] i;
    logic [31:0]   z;
    logic [31:0]   a;
  } job_t;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic           job_valid = 1'b0, job_ready;
  logic [CW-1:0]  job_real = '0, job_imag = '0;
  logic [31:0]    job_zoom = '0, job_addr = '0;
  logic           sol_rdy = 1'b1, force_low = 1'b0, solver_ready;
  logic           write_real_en, write_imag_en, start, busy;
  logic [LIB-1:0] write_limb;
  logic [LS-1:0]  write_data;
  logic [31:0]    zoom_level, output_addr;
`ifdef TILE_DISPATCHER_STATS_EN
  logic [31:0]    jobs_done, stall_cycles;
`endif

  assign solver_ready = sol_rdy && !force_low;

  tile_dispatcher #(.LIMB_INDEX_BITS(LIB), .LIMB_SIZE_BITS(LS), .NUM_LIMBS(N)) dut (
    .clock(clk), .reset(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_real(job_real), .job_imag(job_imag), .job_zoom(job_zoom), .job_addr(job_addr),
    .solver_ready(solver_ready),
    .write_real_en(write_real_en), .write_imag_en(write_imag_en),
    .write_limb(write_limb), .write_data(write_data),
    .zoom_level(zoom_level), .output_addr(output_addr),
    .start(start), .busy(busy)
`ifdef TILE_DISPATCHER_STATS_EN
    , .jobs_done(jobs_done), .stall_cycles(stall_cycles)
`endif
  );

  int checks = 0, errors = 0, cyc = 0;
  int busy_len = 4, sol_cnt = 0, rise_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // solver stand-in: drops ready after start, returns it busy_len cycles later
  always @(negedge clk)
    if (rst) begin
      sol_rdy = 1'b1;
      sol_cnt = 0;
    end else if (start) begin
      sol_rdy = 1'b0;
      sol_cnt = busy_len;
    end else if (sol_cnt > 0) begin
      sol_cnt--;
      if (sol_cnt == 0) begin
        sol_rdy  = 1'b1;
        rise_cyc = cyc;
      end
    end

  // reference: job timeline t (-1 idle, 0..2N-1 limb writes, 2N start, 2N+1 await drop, 2N+2 await rise)
  job_t           m_pend = '0, m_act = '0;
  bit             m_full = 1'b0;
  int             m_t = -1;
  logic [LIB-1:0] m_limb = '0;
  logic [LS-1:0]  m_data = '0;
  logic [31:0]    m_jobs = '0, m_stall = '0;

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_full = 1'b0; m_t = -1; m_act = '0; m_limb = '0; m_data = '0; m_jobs = '0; m_stall = '0;
    end else begin
      bit disp, acc;
      logic [CW-1:0] src;
      disp = m_t < 0 && m_full && solver_ready;
      acc  = job_valid && !m_full;
      if (m_t < 0 && m_full && !solver_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (m_t >= 0 && m_t <= 2 * N) m_t++;
      else if (m_t == 2 * N + 1 && !solver_ready) m_t++;
      else if (m_t == 2 * N + 2 && solver_ready) begin m_t = -1; m_jobs++; end
      if (disp) begin m_act = m_pend; m_full = 1'b0; m_t = 0; end
      if (acc) begin m_pend = {job_real, job_imag, job_zoom, job_addr}; m_full = 1'b1; end
      if (m_t >= 0 && m_t < 2 * N) begin
        src    = m_t < N ? m_act.r : m_act.i;
        m_limb = LIB'(m_t % N);
        m_data = src[(m_t % N) * LS +: LS];
      end
    end

  // every-cycle comparison against the model
  always @(negedge clk)
    if (!rst) begin
      chk("job_ready", job_ready, !m_full);
      chk("write_real_en", write_real_en, m_t >= 0 && m_t < N);
      chk("write_imag_en", write_imag_en, m_t >= N && m_t < 2 * N);
      chk("write_limb", write_limb, m_limb);
      chk("write_data", write_data, m_data);
      chk("start", start, m_t == 2 * N);
      chk("busy", busy, m_t >= 0);
      chk("zoom_level", zoom_level, m_act.z);
      chk("output_addr", output_addr, m_act.a);
`ifdef TILE_DISPATCHER_STATS_EN
      chk("jobs_done", jobs_done, m_jobs);
      chk("stall_cycles", stall_cycles, m_stall);
`endif
    end

  function automatic job_t rnd_job();
    job_t j;
    for (int k = 0; k < N; k++) begin
      j.r[k*LS +: LS] = LS'($urandom);
      j.i[k*LS +: LS] = LS'($urandom);
    end
    j.z = $urandom;
    j.a = $urandom;
    return j;
  endfunction

  task automatic drive(input job_t j);
    job_real = j.r; job_imag = j.i; job_zoom = j.z; job_addr = j.a;
  endtask

  task automatic submit(input job_t j);
    int n;
    n = 0;
    @(negedge clk);
    job_valid = 1'b1;
    drive(j);
    while (!job_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin checks++; errors++; $display("FAIL submit_timeout: job_ready 0 expected 1"); end
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(!busy && job_ready && solver_ready) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin checks++; errors++; $display("FAIL idle_timeout: busy %0b expected 0", busy); end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    job_t a, b, f;
    int n;
    repeat (2) @(negedge clk);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_wre", write_real_en, 0);
    chk("rst_wie", write_imag_en, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_zoom", zoom_level, 0);
    chk("rst_addr", output_addr, 0);
    #2 rst = 1'b0;

    // single job with literal timing, limbs 1..4 / 5..8
    wait_idle();
    busy_len = 3;
    job_valid = 1'b1;
    job_real = {27'd4, 27'd3, 27'd2, 27'd1};
    job_imag = {27'd8, 27'd7, 27'd6, 27'd5};
    job_zoom = 32'd3;
    job_addr = 32'h1000;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) job_valid = 1'b0;
      chk("t1_ready", job_ready, k != 1);
      chk("t1_wre", write_real_en, k >= 2 && k <= 5);
      chk("t1_wie", write_imag_en, k >= 6 && k <= 9);
      chk("t1_start", start, k == 10);
      if (k >= 2 && k <= 9) begin
        chk("t1_limb", write_limb, (k - 2) % 4);
        chk("t1_data", write_data, k - 1);
      end
      if (k >= 2) begin
        chk("t1_zoom", zoom_level, 3);
        chk("t1_addr", output_addr, 32'h1000);
      end
    end

    // back-to-back jobs, solver busy 16 cycles
    wait_idle();
    busy_len = 16;
    a = rnd_job();
    b = rnd_job();
    submit(a);
    submit(b);
    chk("t2_b_during_a", busy, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      chk("t2_a_zoom", zoom_level, a.z);
      chk("t2_a_addr", output_addr, a.a);
      chk("t2_b_pending", job_ready, 0);
    end while (busy && n < 200);
    @(negedge clk);
    chk("t2_b_wre", write_real_en, 1);
    chk("t2_b_latency", cyc - rise_cyc, 2);
    chk("t2_b_zoom", zoom_level, b.z);
    chk("t2_b_freed", job_ready, 1);

    // solver_ready held low while a job waits in IDLE
    wait_idle();
    busy_len = 4;
    force_low = 1'b1;
    submit(rnd_job());
    repeat (6) begin
      @(negedge clk);
      chk("t3_wre", write_real_en, 0);
      chk("t3_busy", busy, 0);
      chk("t3_ready", job_ready, 0);
    end
    force_low = 1'b0;
    @(negedge clk);
    chk("t3_dispatch", write_real_en, 1);
    chk("t3_limb0", write_limb, 0);

    // reset during WR_IMAG limb 2 with a job pending
    wait_idle();
    busy_len = 5;
    submit(rnd_job());
    submit(rnd_job());
    n = 0;
    while (!(write_imag_en && write_limb == 2) && n < 100) begin @(negedge clk); n++; end
    chk("t4_reached_imag2", write_imag_en && write_limb == 2, 1);
    #2 rst = 1'b1;
    #1;
    chk("t4_wre", write_real_en, 0);
    chk("t4_wie", write_imag_en, 0);
    chk("t4_start", start, 0);
    chk("t4_busy", busy, 0);
    chk("t4_ready", job_ready, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t4_pending_dropped", busy, 0);
    f = rnd_job();
    submit(f);
    n = 0;
    while (!write_real_en && n < 20) begin @(negedge clk); n++; end
    chk("t4_restart_limb", write_limb, 0);
    chk("t4_restart_data", write_data, f.r[LS-1:0]);

    // randomized traffic, solver stalls and occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      job_valid = $urandom_range(0, 2) == 0;
      drive(rnd_job());
      busy_len = $urandom_range(2, 20);
      if ($urandom_range(0, 40) == 0) force_low = !force_low;
      if ($urandom_range(0, 600) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    job_valid = 1'b0;
    force_low = 1'b0;
    wait_idle();

`ifdef TILE_DISPATCHER_STATS_EN
    // three jobs, the first blocked for five IDLE cycles
    pulse_reset();
    busy_len = 3;
    force_low = 1'b1;
    @(negedge clk);
    job_valid = 1'b1;
    drive(rnd_job());
    @(negedge clk);
    job_valid = 1'b0;
    repeat (5) @(negedge clk);
    force_low = 1'b0;
    wait_idle();
    submit(rnd_job());
    wait_idle();
    submit(rnd_job());
    wait_idle();
    chk("stats_jobs_done", jobs_done, 3);
    chk("stats_stall_cycles", stall_cycles, 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tile_dispatcher.md
Name: tile_dispatcher

Overview:
- Upstream feeder for tile_solver.
- Accepts one tile job per valid/ready handshake: real/imag coordinates as NUM_LIMBS limbs, zoom level and output address.
- Buffers one pending job behind the active one, streams the active job's limbs into the solver's limb-write port and pulses start.
- Tracks solver ready so a new job is never issued while the solver runs.

Parameters:
- LIMB_INDEX_BITS, 6, width of solver limb index.
- LIMB_SIZE_BITS, 27, width of one limb.
- NUM_LIMBS, 4, limbs per coordinate; legal range 1 to 2**LIMB_INDEX_BITS.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- job_valid  in  1  job offered.
- job_ready  out  1  pending buffer empty; job accepted when valid&&ready.
- job_real  in  NUM_LIMBS*LIMB_SIZE_BITS  real coordinate; limb k = bits [k*LIMB_SIZE_BITS +: LIMB_SIZE_BITS].
- job_imag  in  NUM_LIMBS*LIMB_SIZE_BITS  imag coordinate, same packing.
- job_zoom  in  32  zoom level.
- job_addr  in  32  output address.
- solver_ready  in  1  solver ready output.
- write_real_en  out  1  real limb write strobe.
- write_imag_en  out  1  imag limb write strobe.
- write_limb  out  LIMB_INDEX_BITS  limb index.
- write_data  out  LIMB_SIZE_BITS  limb value.
- zoom_level  out  32  active job zoom.
- output_addr  out  32  active job address.
- start  out  1  one-cycle start pulse.
- busy  out  1  state != IDLE.

Behaviour:
- All outputs are registered. Async reset values:
  - job_ready=1.
  - All other outputs 0.
  - Pending buffer empty, state IDLE.
- Pending buffer (one entry):
  - Captured on handshake; job_ready falls the next cycle.
  - Freed when copied to the active registers; job_ready rises the next cycle.
  - Accept and free in the same cycle is impossible: the buffer is never both full and empty.
- FSM states: IDLE, WR_REAL, WR_IMAG, START, WAIT_DROP, WAIT_DONE.
- IDLE:
  - If pending full and solver_ready=1: copy pending to active (coords, zoom_level, output_addr), free pending, go to WR_REAL with limb counter 0.
  - Otherwise stay in IDLE.
- WR_REAL:
  - Each cycle, drive write_real_en=1, write_limb=counter, write_data=active real limb[counter].
  - Limbs go out in ascending order, one per cycle.
  - After limb NUM_LIMBS-1, reset counter and go to WR_IMAG.
- WR_IMAG:
  - Same as WR_REAL with write_imag_en; go to START after the last limb.
- Strobes:
  - Never both high.
  - write_limb/write_data hold their last value when strobes are low.
- START: start=1 for exactly one cycle, then go to WAIT_DROP.
- WAIT_DROP: stay while solver_ready=1; go to WAIT_DONE when 0.
- WAIT_DONE: stay while solver_ready=0; go to IDLE when 1.
- Latency:
  - Handshake at cycle H with solver idle gives first write_real_en at H+2.
  - start at H+2+2*NUM_LIMBS.
- zoom_level/output_addr:
  - Change only at the IDLE-to-WR_REAL copy.
  - Held stable through the solver run.
- Pending refill: a new job may be accepted during any non-IDLE state; it waits in pending.
- solver_ready low in IDLE: no dispatch; pending is held.
- Reset mid-job:
  - Everything returns to reset values immediately.
  - Pending job is discarded.
  - Strobes and start drop asynchronously.

Optional Feature:
- Macro: TILE_DISPATCHER_STATS_EN.
- Defined:
  - Adds output port jobs_done [31:0], reset 0.
  - Increments on each WAIT_DONE-to-IDLE transition; wraps 0xFFFFFFFF to 0.
  - Adds output port stall_cycles [31:0], incremented in each IDLE cycle where pending is full and solver_ready=0; saturates at 0xFFFFFFFF.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- Shared package fractal_pkg holds:
  - The FSM state encoding typedef (3-bit).
  - Default constants LIMB_INDEX_BITS=6 and LIMB_SIZE_BITS=27, shared with tile_solver.
- One natural sub-module, tile_job_buffer: the one-entry pending register with valid/ready logic.
- The FSM and limb streaming stay in tile_dispatcher.

Test Plan:
- Reset, then a single job with NUM_LIMBS=4, real limbs 1,2,3,4, imag 5,6,7,8, zoom 3, addr 0x1000, solver model idle; handshake at cycle 0 -> required response:
  - write_real_en cycles 2-5 with limb 0-3 / data 1-4.
  - write_imag_en cycles 6-9 with data 5-8.
  - start at cycle 10 only.
  - zoom_level=3 and output_addr=0x1000 from cycle 2.
- Back-to-back jobs A then B, solver model busy for 16 cycles after start -> required response:
  - B accepted during A's run; job_ready=0 until B is copied.
  - B's first write occurs 2 cycles after solver_ready returns to 1.
  - A's zoom/addr stay stable throughout A's run.
- solver_ready forced low while a job is pending in IDLE -> required response:
  - No strobes, busy=0, job_ready=0.
  - Dispatch begins the cycle after solver_ready rises.
- Assert reset during WR_IMAG limb 2 -> required response:
  - All strobes, start and busy are 0 immediately; job_ready=1.
  - The next job streams from limb 0.
- Limb boundary with LIMB_INDEX_BITS=2, NUM_LIMBS=4 -> required response: write_limb sequence 0,1,2,3 for real and for imag, with no wrap before WR_IMAG.
- With TILE_DISPATCHER_STATS_EN, run 3 jobs with 5 blocked cycles -> required response: jobs_done=3 and stall_cycles=5.
